dec_word_packer: RTL and testbench

Downstream output stage of `polar_decoder`. It takes the serial stream of decoded information bits produced by the successive-cancellation core, one packet at a time. Each packet is packed LSB-first into a single 140-bit word and written to the decoded-bit memory at an address equal to the packet index. After the number of packets announced in the LLR header (word 0, bits [5:0]) has been written, the stage raises a done flag that the top level uses to drive `proc_done`.

---
 rtl/dec_word_packer.sv | 144 ++++++++++++++
 tb/tb_dec_word_packer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dec_word_packer.sv
// dec_word_packer: packs the serial decoded info-bit stream of each packet
// LSB-first into one DATA_W-bit word, writes it to the decoded-bit memory at
// the packet index, and flags completion once all announced packets are out.
module dec_word_packer #(
    parameter int DATA_W = 140,
    parameter int ADDR_W = 6,
    parameter int CNT_W  = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_pack_num,
    input  logic              i_bit_valid,
    input  logic              i_bit,
    input  logic              i_bit_last,
    output logic              o_bit_ready,
    output logic              o_wen,
    output logic [ADDR_W-1:0] o_waddr,
    output logic [DATA_W-1:0] o_wdata,
    output logic              o_done,
    output logic              o_err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_WRITE,
        ST_DONE
    } state_t;

    localparam logic [CNT_W-1:0] BCNT_MAX = CNT_W'(DATA_W);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pack_num_q, pack_num_d;
    logic [ADDR_W-1:0]   pcnt_q, pcnt_d;
    logic [CNT_W-1:0]    bcnt_q, bcnt_d;
    logic [DATA_W-1:0]   buf_q, buf_d;
    logic                err_q, err_d;
    logic                wen_q, wen_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                done_q, done_d;

    logic [DATA_W-1:0]   word_ins;
    logic [ADDR_W:0]     pcnt_inc;
    logic                full;

    // State register and all datapath/output registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            pack_num_q <= '0;
            pcnt_q     <= '0;
            bcnt_q     <= '0;
            buf_q      <= '0;
            err_q      <= 1'b0;
            wen_q      <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pack_num_q <= pack_num_d;
            pcnt_q     <= pcnt_d;
            bcnt_q     <= bcnt_d;
            buf_q      <= buf_d;
            err_q      <= err_d;
            wen_q      <= wen_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            done_q     <= done_d;
        end
    end

    // Next-state, packing and write-strobe logic; i_start wins in every state
    always_comb begin
        state_d    = state_q;
        pack_num_d = pack_num_q;
        pcnt_d     = pcnt_q;
        bcnt_d     = bcnt_q;
        buf_d      = buf_q;
        err_d      = err_q;
        wen_d      = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;

        full     = (bcnt_q == BCNT_MAX);
        pcnt_inc = {1'b0, pcnt_q} + (ADDR_W + 1)'(1);

        // word as it looks with the presented bit inserted (unchanged when full)
        word_ins = buf_q;
        if (!full) begin
            word_ins[bcnt_q] = i_bit;
        end

        if (i_start) begin
            pack_num_d = i_pack_num;
            pcnt_d     = '0;
            bcnt_d     = '0;
            buf_d      = '0;
            err_d      = 1'b0;
            state_d    = (i_pack_num == '0) ? ST_DONE : ST_COLLECT;
        end else begin
            case (state_q)
                ST_COLLECT: begin
                    if (i_bit_valid) begin
                        if (full) begin
                            err_d = 1'b1;
                        end else begin
                            buf_d  = word_ins;
                            bcnt_d = bcnt_q + CNT_W'(1);
                        end
                        if (i_bit_last) begin
                            // word goes straight to the output register; buffer
                            // is cleared here so the next packet starts empty
                            wen_d   = 1'b1;
                            waddr_d = pcnt_q;
                            wdata_d = word_ins;
                            buf_d   = '0;
                            bcnt_d  = '0;
                            state_d = ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    pcnt_d  = pcnt_q + ADDR_W'(1);
                    state_d = (pcnt_inc < {1'b0, pack_num_q}) ? ST_COLLECT : ST_DONE;
                end
                default: begin
                end
            endcase
        end

        done_d = (state_d == ST_DONE);
    end

    assign o_bit_ready = (state_q == ST_COLLECT);
    assign o_wen       = wen_q;
    assign o_waddr     = waddr_q;
    assign o_wdata     = wdata_q;
    assign o_done      = done_q;
    assign o_err       = err_q;

endmodule

// File: tb/tb_dec_word_packer.sv
// Testbench for dec_word_packer: randomized packet streams with stalls,
// expected memory writes queued by the driver and checked by a monitor.
module tb_dec_word_packer;

    logic         clk;
    logic         i_rst;
    logic         i_start;
    logic [5:0]   i_pack_num;
    logic         i_bit_valid;
    logic         i_bit;
    logic         i_bit_last;
    logic         o_bit_ready;
    logic         o_wen;
    logic [5:0]   o_waddr;
    logic [139:0] o_wdata;
    logic         o_done;
    logic         o_err;

    dec_word_packer #(.DATA_W(140), .ADDR_W(6), .CNT_W(8)) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_start     (i_start),
        .i_pack_num  (i_pack_num),
        .i_bit_valid (i_bit_valid),
        .i_bit       (i_bit),
        .i_bit_last  (i_bit_last),
        .o_bit_ready (o_bit_ready),
        .o_wen       (o_wen),
        .o_waddr     (o_waddr),
        .o_wdata     (o_wdata),
        .o_done      (o_done),
        .o_err       (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]   addr;
        logic [139:0] data;
        logic         err;
        logic         more;
        logic         follow;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // job-level reference state
    int   job_num  = 0;
    int   job_pcnt = 0;
    bit   job_err  = 0;

    bit   follow_pending = 0;
    bit   follow_more    = 0;

    task automatic chk(input string nm, input logic [139:0] act, input logic [139:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // monitor: pops expected writes when the DUT strobes o_wen
    always @(negedge clk) begin
        exp_t e;
        if (follow_pending) begin
            follow_pending = 0;
            chk("after_write_ready", o_bit_ready, follow_more);
            chk("after_write_done", o_done, !follow_more);
        end
        if (o_wen) begin
            if (q.size() == 0) begin
                chk("unexpected_wen", o_wen, 0);
            end else begin
                e = q.pop_front();
                chk("waddr", o_waddr, e.addr);
                chk("wdata", o_wdata, e.data);
                chk("err_at_write", o_err, e.err);
                chk("ready_during_write", o_bit_ready, 0);
                if (e.follow) begin
                    follow_pending = 1;
                    follow_more    = e.more;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int n, input bit with_bit);
        i_start     = 1;
        i_pack_num  = n[5:0];
        i_bit_valid = with_bit;
        i_bit       = 1;
        i_bit_last  = 1;
        cyc();
        i_start     = 0;
        i_bit_valid = 0;
        i_bit_last  = 0;
        job_num  = n;
        job_pcnt = 0;
        job_err  = 0;
        chk("start_ready", o_bit_ready, n != 0);
        chk("start_done", o_done, n == 0);
        chk("start_err", o_err, 0);
    endtask

    task automatic send_packet(input logic [159:0] bits, input int len, input int stall_pct,
                               input bit give_last, input bit follow);
        int k = 0;
        int wait_cnt = 0;
        bit v;
        bit rdy;
        exp_t e;
        while (k < len) begin
            v = ($urandom_range(99) >= stall_pct);
            i_bit_valid = v;
            i_bit       = bits[k];
            i_bit_last  = give_last && (k == len - 1);
            rdy = o_bit_ready;
            cyc();
            if (v && rdy) begin
                k++;
                wait_cnt = 0;
            end else if (!rdy) begin
                wait_cnt++;
                if (wait_cnt > 200) begin
                    chk("ready_timeout", rdy, 1);
                    break;
                end
            end
        end
        i_bit_valid = 0;
        i_bit_last  = 0;
        if (give_last && k == len) begin
            e.data = '0;
            for (int i = 0; i < len && i < 140; i++) e.data[i] = bits[i];
            if (len > 140) job_err = 1;
            e.addr   = job_pcnt[5:0];
            e.err    = job_err;
            e.more   = (job_pcnt + 1 < job_num);
            e.follow = follow;
            q.push_back(e);
            job_pcnt++;
        end
    endtask

    task automatic check_all_zero(input string pfx);
        chk({pfx, "_ready"}, o_bit_ready, 0);
        chk({pfx, "_wen"}, o_wen, 0);
        chk({pfx, "_waddr"}, o_waddr, 0);
        chk({pfx, "_wdata"}, o_wdata, 0);
        chk({pfx, "_done"}, o_done, 0);
        chk({pfx, "_err"}, o_err, 0);
    endtask

    task automatic ignored_bits(input string nm, input int n);
        for (int i = 0; i < n; i++) begin
            i_bit_valid = 1;
            i_bit       = 1;
            i_bit_last  = i[0];
            cyc();
            chk(nm, o_bit_ready, 0);
        end
        i_bit_valid = 0;
        i_bit_last  = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [159:0] b;
        int n;

        i_rst = 1; i_start = 0; i_pack_num = '0;
        i_bit_valid = 0; i_bit = 0; i_bit_last = 0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        i_rst = 0;
        cyc();

        // single 8-bit packet -> 0x8D at addr 0
        do_start(1, 0);
        b = '0; b[7:0] = 8'h8D;
        send_packet(b, 8, 0, 1, 1);
        cyc();
        chk("single_done", o_done, 1);
        chk("single_err", o_err, 0);

        // three full-width alternating packets with stalls
        do_start(3, 0);
        b = '0;
        for (int i = 0; i < 140; i++) b[i] = i[0];
        for (int p = 0; p < 3; p++) send_packet(b, 140, 30, 1, 1);
        cyc();
        chk("multi_done", o_done, 1);

        // overflow: 145 ones
        do_start(1, 0);
        send_packet('1, 145, 10, 1, 1);
        cyc();
        chk("ovf_err_sticky", o_err, 1);
        chk("ovf_done", o_done, 1);

        // zero packets
        do_start(0, 0);
        ignored_bits("zero_ready", 5);
        chk("zero_done_hold", o_done, 1);

        // abort mid-packet while err set
        do_start(4, 0);
        b = {$urandom, $urandom, $urandom, $urandom, $urandom};
        send_packet(b, 142, 20, 1, 1);
        b = {$urandom, $urandom, $urandom, $urandom, $urandom};
        send_packet(b, 50, 20, 0, 1);
        chk("abort_err_before", o_err, 1);
        do_start(2, 1);
        b = {$urandom, $urandom, $urandom, $urandom, $urandom};
        send_packet(b, 20, 20, 1, 1);
        b = {$urandom, $urandom, $urandom, $urandom, $urandom};
        send_packet(b, 30, 20, 1, 1);
        cyc();
        chk("abort_done", o_done, 1);
        chk("abort_err_after", o_err, 0);

        // reset during COLLECT
        do_start(2, 0);
        b = {$urandom, $urandom, $urandom, $urandom, $urandom};
        send_packet(b, 10, 0, 0, 1);
        i_rst = 1; i_bit_valid = 1;
        cyc();
        i_rst = 0; i_bit_valid = 0;
        check_all_zero("rst_collect");
        ignored_bits("rst_collect_ignore", 4);

        // reset during WRITE
        do_start(2, 0);
        b = {$urandom, $urandom, $urandom, $urandom, $urandom};
        send_packet(b, 5, 0, 1, 0);
        i_rst = 1;
        cyc();
        i_rst = 0;
        check_all_zero("rst_write");
        ignored_bits("rst_write_ignore", 4);

        // random jobs
        for (int j = 0; j < 4; j++) begin
            n = $urandom_range(4, 1);
            do_start(n, $urandom_range(1));
            for (int p = 0; p < n; p++) begin
                b = {$urandom, $urandom, $urandom, $urandom, $urandom};
                send_packet(b, $urandom_range(150, 1), $urandom_range(40), 1, 1);
            end
            cyc();
            chk("rand_done", o_done, 1);
            chk("rand_err", o_err, job_err);
        end

        repeat (3) cyc();
        chk("scoreboard_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
